// File: rtl/force_pkt_router.sv
// Purpose: per-channel force-packet FIFOs split by dest_id onto a network port and a local port.
// Latency: 2 cycles from push to registered output valid (FIFO head in t+1, output reg in t+2).
// Backpressure: in_ready = FIFO not full; a stalled output holds its register and blocks
//               channels whose head targets it (head-of-line blocking per channel).

// Small generic FIFO: head is combinational from storage, push refused when full.
module pkt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at a power-of-2 depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module force_pkt_router #(
  parameter  int NUM_CH            = 4,
  parameter  int FIFO_DEPTH        = 4,
  parameter  int DATA_WIDTH        = 32,
  parameter  int PARTICLE_ID_WIDTH = 7,
  parameter  int NODE_ID_WIDTH     = 6,
  localparam int PAY_W             = PARTICLE_ID_WIDTH + 3*DATA_WIDTH,
  localparam int PKT_W             = NODE_ID_WIDTH + PAY_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NODE_ID_WIDTH-1:0] local_node_id,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*PKT_W-1:0]  in_pkt,
  output logic                     net_valid,
  input  logic                     net_ready,
  output logic [PKT_W-1:0]         net_pkt,
  output logic                     loc_valid,
  input  logic                     loc_ready,
  output logic [PAY_W-1:0]         loc_data,
  output logic [NUM_CH-1:0]        fifo_full
);
  localparam int CH_W = $clog2(NUM_CH);

  typedef struct packed {
    logic [NODE_ID_WIDTH-1:0]     dest_id;
    logic [PARTICLE_ID_WIDTH-1:0] particle_id;
    logic [DATA_WIDTH-1:0]        force_z;
    logic [DATA_WIDTH-1:0]        force_y;
    logic [DATA_WIDTH-1:0]        force_x;
  } pkt_t;

  pkt_t              head [NUM_CH];
  logic [NUM_CH-1:0] empty, full, push, pop, net_req, loc_req;
  logic [CH_W-1:0]   net_ptr, loc_ptr, net_idx, loc_idx;
  logic [CH_W:0]     net_pick, loc_pick;
  logic              net_found, loc_found, net_load, loc_load, net_gnt, loc_gnt;

  // Round-robin search from ptr; returns {found, index of first requester}.
  function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                            input logic [CH_W-1:0]   ptr);
    logic [CH_W:0] r;
    int            idx;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_CH;
      if (req[CH_W'(idx)]) r = {1'b1, CH_W'(idx)};
    end
    return r;
  endfunction

  function automatic logic [CH_W-1:0] rr_next(input logic [CH_W-1:0] k);
    return (k == CH_W'(NUM_CH - 1)) ? '0 : k + CH_W'(1);
  endfunction

  assign in_ready  = ~full;
  assign fifo_full = full;
  assign push      = in_valid & ~full;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pkt_fifo #(.WIDTH(PKT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push[c]),
      .push_dat (in_pkt[c*PKT_W +: PKT_W]),
      .pop      (pop[c]),
      .head_dat (head[c]),
      .empty    (empty[c]),
      .full     (full[c])
    );
  end

  // Classify each non-empty head as local or network traffic.
  always_comb begin
    net_req = '0;
    loc_req = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      loc_req[c] = !empty[c] && (head[c].dest_id == local_node_id);
      net_req[c] = !empty[c] && (head[c].dest_id != local_node_id);
    end
  end

  assign net_pick  = rr_pick(net_req, net_ptr);
  assign loc_pick  = rr_pick(loc_req, loc_ptr);
  assign net_found = net_pick[CH_W];
  assign loc_found = loc_pick[CH_W];
  assign net_idx   = net_pick[CH_W-1:0];
  assign loc_idx   = loc_pick[CH_W-1:0];
  assign net_load  = !net_valid || net_ready;
  assign loc_load  = !loc_valid || loc_ready;
  assign net_gnt   = net_load && net_found;
  assign loc_gnt   = loc_load && loc_found;

  // Pop granted heads; a head is in one class only, so each channel pops at most once.
  always_comb begin
    pop = '0;
    if (net_gnt) pop[net_idx] = 1'b1;
    if (loc_gnt) pop[loc_idx] = 1'b1;
  end

  // Network output register and its round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      net_valid <= 1'b0;
      net_pkt   <= '0;
      net_ptr   <= '0;
    end else if (net_load) begin
      net_valid <= net_found;
      if (net_found) begin
        net_pkt <= head[net_idx];
        net_ptr <= rr_next(net_idx);
      end
    end
  end

  // Local output register: payload only, dest_id stripped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loc_valid <= 1'b0;
      loc_data  <= '0;
      loc_ptr   <= '0;
    end else if (loc_load) begin
      loc_valid <= loc_found;
      if (loc_found) begin
        loc_data <= {head[loc_idx].particle_id, head[loc_idx].force_z,
                     head[loc_idx].force_y, head[loc_idx].force_x};
        loc_ptr  <= rr_next(loc_idx);
      end
    end
  end
endmodule

// File: tb/tb_force_pkt_router.sv
module tb_force_pkt_router;
  localparam int NUM_CH = 4;
  localparam int DW     = 32;
  localparam int PIDW   = 7;
  localparam int NIDW   = 6;
  localparam int PAY_W  = PIDW + 3*DW;
  localparam int PKT_W  = NIDW + PAY_W;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NIDW-1:0]         local_node_id = 6'd5;
  logic [NUM_CH-1:0]       in_valid = '0;
  logic [NUM_CH-1:0]       in_ready;
  logic [NUM_CH*PKT_W-1:0] in_pkt = '0;
  logic                    net_valid, loc_valid;
  logic                    net_ready = 1'b1;
  logic                    loc_ready = 1'b1;
  logic [PKT_W-1:0]        net_pkt;
  logic [PAY_W-1:0]        loc_data;
  logic [NUM_CH-1:0]       fifo_full;

  int checks = 0;
  int errors = 0;
  logic [PKT_W-1:0] exp_net[$];
  logic [PAY_W-1:0] exp_loc[$];

  force_pkt_router #(
    .NUM_CH(NUM_CH), .FIFO_DEPTH(4), .DATA_WIDTH(DW),
    .PARTICLE_ID_WIDTH(PIDW), .NODE_ID_WIDTH(NIDW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .local_node_id(local_node_id),
    .in_valid(in_valid), .in_ready(in_ready), .in_pkt(in_pkt),
    .net_valid(net_valid), .net_ready(net_ready), .net_pkt(net_pkt),
    .loc_valid(loc_valid), .loc_ready(loc_ready), .loc_data(loc_data),
    .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  function automatic logic [PKT_W-1:0] mk(input int d, input int p, input int x,
                                          input int y, input int z);
    return {NIDW'(d), PIDW'(p), DW'(z), DW'(y), DW'(x)};
  endfunction

  function automatic logic [PAY_W-1:0] pay(input logic [PKT_W-1:0] p);
    return p[PAY_W-1:0];
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input logic [PKT_W-1:0] p);
    in_valid[ch] = 1'b1;
    in_pkt[ch*PKT_W +: PKT_W] = p;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_net.size() != 0 || exp_loc.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check(name, 128'(exp_net.size() + exp_loc.size()), 128'(0));
  endtask

  // Scoreboard monitor: a transfer happens at the next posedge when valid & ready now.
  always @(negedge clk) begin
    if (rst_n) begin
      if (net_valid && net_ready) begin
        checks++;
        if (exp_net.size() == 0) begin
          errors++;
          $display("FAIL net_unexpected: got %h expected nothing", net_pkt);
        end else begin
          logic [PKT_W-1:0] e;
          e = exp_net.pop_front();
          if (net_pkt !== e) begin
            errors++;
            $display("FAIL net_pkt: got %h expected %h", net_pkt, e);
          end
        end
      end
      if (loc_valid && loc_ready) begin
        checks++;
        if (exp_loc.size() == 0) begin
          errors++;
          $display("FAIL loc_unexpected: got %h expected nothing", loc_data);
        end else begin
          logic [PAY_W-1:0] e;
          e = exp_loc.pop_front();
          if (loc_data !== e) begin
            errors++;
            $display("FAIL loc_data: got %h expected %h", loc_data, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PKT_W-1:0] p;
    logic [PKT_W-1:0] pk [6];

    // Reset state
    tick(); tick();
    check("rst_net_valid", 128'(net_valid), 128'(0));
    check("rst_loc_valid", 128'(loc_valid), 128'(0));
    check("rst_net_pkt", 128'(net_pkt), 128'(0));
    check("rst_loc_data", 128'(loc_data), 128'(0));
    check("rst_fifo_full", 128'(fifo_full), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'hF);
    rst_n = 1'b1;
    tick();

    // 1: single local packet, latency 2
    p = mk(5, 3, 1, 2, 3);
    exp_loc.push_back(pay(p));
    drive(0, p);
    tick();
    in_valid = '0;
    check("t1_loc_valid_t1", 128'(loc_valid), 128'(0));
    tick();
    check("t1_loc_valid_t2", 128'(loc_valid), 128'(1));
    check("t1_loc_data", 128'(loc_data), {21'd0, 7'd3, 32'd3, 32'd2, 32'd1});
    check("t1_net_valid", 128'(net_valid), 128'(0));
    wait_drain("t1_drain", 20);

    // 2: all channels push net packets at once -> ch0..ch3 back to back
    for (int c = 0; c < NUM_CH; c++) begin
      p = mk(9, 10 + c, c, c + 1, c + 2);
      exp_net.push_back(p);
      drive(c, p);
    end
    tick();
    in_valid = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      tick();
      check("t2_net_valid_run", 128'(net_valid), 128'(1));
    end
    tick();
    check("t2_net_valid_end", 128'(net_valid), 128'(0));
    // net_ptr back at 0: ch0 must win over ch3
    p = mk(9, 20, 7, 7, 7);
    exp_net.push_back(p);
    drive(0, p);
    p = mk(9, 23, 8, 8, 8);
    exp_net.push_back(p);
    drive(3, p);
    tick();
    in_valid = '0;
    wait_drain("t2_drain", 20);

    // 3: net stalled, 5 packets fill reg + FIFO, 6th refused
    net_ready = 1'b0;
    for (int i = 0; i < 6; i++) pk[i] = mk(9, 30 + i, 100 + i, 200 + i, 300 + i);
    for (int i = 0; i < 5; i++) begin
      exp_net.push_back(pk[i]);
      drive(1, pk[i]);
      tick();
    end
    check("t3_fifo_full", 128'(fifo_full[1]), 128'(1));
    check("t3_in_ready", 128'(in_ready[1]), 128'(0));
    drive(1, pk[5]);
    tick();
    in_valid = '0;
    check("t3_still_full", 128'(fifo_full[1]), 128'(1));
    check("t3_held_pkt", 128'(net_pkt), 128'(pk[0]));
    net_ready = 1'b1;
    wait_drain("t3_drain", 30);
    tick();
    check("t3_not_full", 128'(fifo_full[1]), 128'(0));

    // 4: ch2 alternates local/net with loc stalled -> head-of-line block
    loc_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      p = mk((i % 2 == 0) ? 5 : 9, 40 + i, i, 2 * i, 3 * i);
      if (i % 2 == 0) exp_loc.push_back(pay(p));
      else            exp_net.push_back(p);
      drive(2, p);
      tick();
    end
    in_valid = '0;
    repeat (6) tick();
    check("t4_net_sent_one", 128'(exp_net.size()), 128'(1));
    check("t4_net_idle", 128'(net_valid), 128'(0));
    check("t4_loc_held", 128'(loc_data), 128'(pay(mk(5, 40, 0, 0, 0))));
    loc_ready = 1'b1;
    wait_drain("t4_drain", 30);

    // 5: local and net heads in the same cycle
    p = mk(5, 50, 11, 12, 13);
    exp_loc.push_back(pay(p));
    drive(0, p);
    p = mk(9, 51, 21, 22, 23);
    exp_net.push_back(p);
    drive(1, p);
    tick();
    in_valid = '0;
    check("t5_both_idle_t1", 128'({net_valid, loc_valid}), 128'(0));
    tick();
    check("t5_both_valid_t2", 128'({net_valid, loc_valid}), 128'(3));
    tick();
    check("t5_both_idle_t3", 128'({net_valid, loc_valid}), 128'(0));
    wait_drain("t5_drain", 10);

    // 6: reset mid-operation discards buffered and held packets
    net_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(3, mk(9, 60 + i, i, i, i));
      tick();
    end
    in_valid = '0;
    tick();
    check("t6_net_valid_pre", 128'(net_valid), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_net_valid", 128'(net_valid), 128'(0));
    check("t6_async_net_pkt", 128'(net_pkt), 128'(0));
    check("t6_async_fifo_full", 128'(fifo_full), 128'(0));
    check("t6_async_in_ready", 128'(in_ready), 128'hF);
    exp_net.delete();
    exp_loc.delete();
    drive(0, mk(9, 70, 1, 1, 1));
    tick();
    in_valid = '0;
    tick();
    #2;
    rst_n = 1'b1;
    net_ready = 1'b1;
    repeat (6) tick();
    check("t6_no_stale", 128'({net_valid, loc_valid}), 128'(0));
    // Router still works after reset
    p = mk(5, 80, 4, 5, 6);
    exp_loc.push_back(pay(p));
    drive(2, p);
    tick();
    in_valid = '0;
    wait_drain("t6_post_drain", 10);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
